// File: rtl/egress_pkg.sv
// Shared types and constants for the egress drain engine.
// Port-configuration defaults live here so the FIFO entry layout is shared.
package egress_pkg;

    localparam int PORTS_DEFAULT  = 4;
    localparam int DATA_W_DEFAULT = 32;
    localparam int WIDTH_SEL      = $clog2(PORTS_DEFAULT);
    localparam int RD_CNT_W       = 16;

    typedef struct packed {
        logic [WIDTH_SEL-1:0]      src;
        logic [DATA_W_DEFAULT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer.
// N must be a power of two so index arithmetic wraps naturally.
module rr_arbiter #(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] gnt_o,
    output logic          gnt_valid_o
);

    logic [SW-1:0] idx;

    // Scan farthest offset first so the nearest request wins last.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr_i + SW'(i);
            if (req_i[idx]) begin
                gnt_o       = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_reader.sv
// Output-port drain engine: round-robin VOQ reads under FIFO credit,
// returned words buffered and streamed downstream tagged with source.
module egress_reader
    import egress_pkg::*;
#(
    parameter int PORT_NUB_TOTAL = PORTS_DEFAULT,
    parameter int DATA_WIDTH     = DATA_W_DEFAULT,
    parameter int RD_LATENCY     = 1,
    parameter int OUT_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORT_NUB_TOTAL-1:0] empty,
    output logic                      rd_en,
    output logic [WIDTH_SEL-1:0]      rd_sel,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [WIDTH_SEL-1:0]      m_src,
    output logic                      busy,
    output logic [RD_CNT_W-1:0]       rd_count
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH_SEL-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WIDTH_SEL-1:0]      sel_q, sel_d;
    logic [PORT_NUB_TOTAL-1:0] mask_q, mask_d;
    logic [RD_CNT_W-1:0]       rdc_q, rdc_d;

    logic [RD_LATENCY-1:0]     fv_q;
    logic [WIDTH_SEL-1:0]      fs_q [RD_LATENCY];

    fifo_entry_t               mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]          wp_q, wp_d;
    logic [PTR_W-1:0]          rp_q, rp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [PORT_NUB_TOTAL-1:0] eligible;
    logic [WIDTH_SEL-1:0]      gnt;
    logic                      gnt_valid;
    logic [CNT_W-1:0]          infl;
    logic [CNT_W:0]            used;
    logic                      credit_ok;
    logic                      issue;
    logic                      push;
    logic                      pop;
    fifo_entry_t               push_entry;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            infl = infl + CNT_W'(fv_q[i]);
        end
    end

    // Credit counts words already buffered plus words still on the wire.
    assign used      = {1'b0, cnt_q} + {1'b0, infl};
    assign credit_ok = used < (CNT_W + 1)'(OUT_DEPTH);

    assign eligible = ~empty & ~mask_q;

    rr_arbiter #(
        .N(PORT_NUB_TOTAL)
    ) u_arb (
        .req_i      (eligible),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid)
    );

    assign issue  = gnt_valid & credit_ok & ~rst;
    assign rd_en  = issue;
    assign rd_sel = issue ? gnt : sel_q;

    assign push            = fv_q[RD_LATENCY-1];
    assign push_entry.src  = fs_q[RD_LATENCY-1];
    assign push_entry.data = rd_data;

    assign m_valid  = (cnt_q != '0);
    assign m_data   = mem_q[rp_q].data;
    assign m_src    = mem_q[rp_q].src;
    assign pop      = m_valid & m_ready;
    assign busy     = (|fv_q) | m_valid;
    assign rd_count = rdc_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        sel_d    = rd_sel;
        mask_d   = '0;
        rdc_d    = rdc_q;
        if (issue) begin
            rr_ptr_d = gnt + WIDTH_SEL'(1);
            mask_d   = PORT_NUB_TOTAL'(1) << gnt;
            rdc_d    = rdc_q + RD_CNT_W'(1);
        end
    end

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
        end
        if (pop) begin
            rp_d = rp_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            mask_q   <= '0;
            rdc_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            fv_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                fs_q[i] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            rdc_q    <= rdc_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            fv_q[0]  <= issue;
            fs_q[0]  <= rd_sel;
            for (int i = 1; i < RD_LATENCY; i++) begin
                fv_q[i] <= fv_q[i-1];
                fs_q[i] <= fs_q[i-1];
            end
            if (push) begin
                mem_q[wp_q] <= push_entry;
            end
        end
    end

endmodule
